// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and the default oversampling ratio.
package uart_pkg;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } uart_state_e;

  localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; reset value is a parameter (defaults to all ones).
module sync_2ff #(
  parameter int              WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/stop bits sampled at mid-bit from a baud_tick oversampled stream.
// Defining UART_RX_PARITY_EN inserts a parity bit and adds the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
`ifdef UART_RX_PARITY_EN
  ,parameter bit ODD_PARITY = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,output logic                parity_err
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    IDX_LAST = 3'(DATA_BITS - 1);

  localparam logic [4:0] S_IDLE   = ST_IDLE;
  localparam logic [4:0] S_START  = ST_START;
  localparam logic [4:0] S_DATA   = ST_DATA;
  localparam logic [4:0] S_STOP   = ST_STOP;
`ifdef UART_RX_PARITY_EN
  localparam logic [4:0] S_PARITY = ST_PARITY;
`endif

  logic                 rx_s;
  logic [4:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                 pbad_q, pbad_d;
  logic                 perr_q, perr_d;
`endif

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_line),
    .q_o (rx_s)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d  = pbad_q;
    perr_d  = 1'b0;
`endif
    if (baud_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d = S_START;
            tick_d  = '0;
          end
        end
        S_START: begin
          if (tick_q == TICK_MID) begin
            // A line that is high again at mid start bit was only a glitch.
            state_d = rx_s ? S_IDLE : S_DATA;
            tick_d  = '0;
            idx_d   = '0;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tick_q == TICK_END) begin
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            tick_d  = '0;
            if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (tick_q == TICK_END) begin
            pbad_d  = ((^shreg_q) ^ rx_s) != ODD_PARITY;
            tick_d  = '0;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (tick_q == TICK_END) begin
            // Leave at mid stop bit so a back-to-back start edge is not missed.
            data_d  = shreg_q;
            tick_d  = '0;
            state_d = S_IDLE;
            ferr_d  = ~rx_s;
`ifdef UART_RX_PARITY_EN
            valid_d = rx_s & ~pbad_q;
            perr_d  = pbad_q;
`else
            valid_d = rx_s;
`endif
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      pbad_q  <= pbad_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign data_out  = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: vector table, hand-written corner sequences and a random frame stream.
module tb_uart_rx;

  localparam int DB  = 8;
  localparam int OS  = 16;
  localparam int DIV = 4;   // clk cycles per baud_tick

  logic          clk = 1'b0;
  logic          rst;
  logic          baud_tick;
  logic          rx_line;
  logic [DB-1:0] data_out;
  logic          rx_valid;
  logic          frame_err;
  logic          busy;
  logic          perr_w;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       perr;
    logic       busy;
    longint     t;
  } event_t;
  event_t evq[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;
  vec_t tbl[8];

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx_line   (rx_line),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,.parity_err(perr_w)
`endif
  );
`ifndef UART_RX_PARITY_EN
  assign perr_w = 1'b0;
`endif

  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (DIV - 1) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  // Every clk with an output pulse becomes one event; a stretched pulse shows up as extra events.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rx_valid || frame_err || perr_w)
      evq.push_back('{data_out, rx_valid, frame_err, perr_w, busy, cyc});
  end

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (baud_tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    rx_line = b;
    wait_ticks(OS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par === 1'bx) $display("parity ignored");
`endif
    send_bit(stop);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx_line = 1'b1;
    wait_ticks(n);
  endtask

  task automatic wait_events(input int n, input int budget_clks);
    int b = budget_clks;
    while (evq.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
  endtask

  task automatic expect_event(input string name, input logic [7:0] d, input logic v,
                              input logic fe, input logic pe);
    event_t e;
    check({name, ".count"}, 64'(evq.size()), 64'd1);
    if (evq.size() > 0) begin
      e = evq.pop_front();
      check({name, ".data"},  64'(e.data),  64'(d));
      check({name, ".valid"}, 64'(e.valid), 64'(v));
      check({name, ".ferr"},  64'(e.ferr),  64'(fe));
      check({name, ".perr"},  64'(e.perr),  64'(pe));
      check({name, ".busy"},  64'(e.busy),  64'd0);
    end
    evq.delete();
  endtask

  initial begin
    event_t     e;
    event_t     exp_q[$];
    logic [7:0] d;
    logic       s;
    int         gap;
    longint     dt;

    rst     = 1'b1;
    rx_line = 1'b1;
    repeat (3) @(negedge clk);
    check("reset.busy", 64'(busy), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.data_out",  64'(data_out),  64'd0);
    check("reset.rx_valid",  64'(rx_valid),  64'd0);
    check("reset.frame_err", 64'(frame_err), 64'd0);
    check("reset.busy_after",64'(busy),      64'd0);
    idle(20);

    tbl[0] = '{8'hA5, 1'b1, 16, 8'hA5, 1'b1, 1'b0};
    tbl[1] = '{8'h3C, 1'b1,  0, 8'h3C, 1'b1, 1'b0};
    tbl[2] = '{8'hC3, 1'b1, 16, 8'hC3, 1'b1, 1'b0};
    tbl[3] = '{8'h55, 1'b0, 32, 8'h55, 1'b0, 1'b1};
    tbl[4] = '{8'h00, 1'b1,  8, 8'h00, 1'b1, 1'b0};
    tbl[5] = '{8'hFF, 1'b1,  0, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{8'h01, 1'b1,  4, 8'h01, 1'b1, 1'b0};
    tbl[7] = '{8'h80, 1'b1, 16, 8'h80, 1'b1, 1'b0};
    evq.delete();
    for (int i = 0; i < 8; i++) begin
      send_frame(tbl[i].data, ^tbl[i].data, tbl[i].stop);
      expect_event($sformatf("vec%0d", i), tbl[i].exp_data, tbl[i].exp_valid, tbl[i].exp_ferr, 1'b0);
      if (tbl[i].gap > 0) idle(tbl[i].gap);
    end

    // Reset during data bit 4 of 0xFF, then a clean 0x12.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    @(negedge clk);
    wait_ticks(8);
    check("midrst.busy_before", 64'(busy), 64'd1);
    @(negedge clk);
    rst     = 1'b1;
    rx_line = 1'b1;
    #1;
    check("midrst.data_out",  64'(data_out),  64'd0);
    check("midrst.busy",      64'(busy),      64'd0);
    check("midrst.rx_valid",  64'(rx_valid),  64'd0);
    check("midrst.frame_err", 64'(frame_err), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(20);
    check("midrst.no_pulse", 64'(evq.size()), 64'd0);
    evq.delete();
    send_frame(8'h12, 1'b0, 1'b1);
    expect_event("after_rst", 8'h12, 1'b1, 1'b0, 1'b0);
    idle(16);

    // Four-tick low glitch on an idle line.
    @(negedge clk);
    rx_line = 1'b0;
    wait_ticks(4);
    @(negedge clk);
    rx_line = 1'b1;
    wait_ticks(2);
    check("glitch.busy_mid", 64'(busy), 64'd1);
    wait_ticks(20);
    check("glitch.no_pulse", 64'(evq.size()), 64'd0);
    check("glitch.busy_end", 64'(busy),       64'd0);
    check("glitch.data_out", 64'(data_out),   64'h12);
    evq.delete();

    // Break: 0x55 with stop 0, line held low -> repeated frame errors about 10 bit periods apart.
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d_of(8'h55, i));
`ifdef UART_RX_PARITY_EN
    send_bit(^8'h55);
`endif
    @(negedge clk);
    rx_line = 1'b0;
    wait_events(4, 4 * 12 * OS * DIV);
    rx_line = 1'b1;
    wait_ticks(40);
    check("break.count", 64'(evq.size()), 64'd4);
    for (int i = 0; i < evq.size() && i < 4; i++) begin
      check($sformatf("break%0d.data", i),  64'(evq[i].data),  (i == 0) ? 64'h55 : 64'h00);
      check($sformatf("break%0d.ferr", i),  64'(evq[i].ferr),  64'd1);
      check($sformatf("break%0d.valid", i), 64'(evq[i].valid), 64'd0);
      if (i > 0) begin
        dt = evq[i].t - evq[i-1].t;
        check($sformatf("break%0d.spacing_ok", i),
              64'((dt >= 9 * OS * DIV) && (dt <= 10 * OS * DIV)), 64'd1);
      end
    end
    evq.delete();
    idle(16);

    // Random frame stream against a queue model of the expected pulses.
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      d   = 8'($urandom_range(0, 255));
      s   = ($urandom_range(0, 99) < 85);
      gap = s ? int'($urandom_range(0, 20)) : int'(16 + $urandom_range(0, 16));
      exp_q.push_back('{d, s, ~s, 1'b0, 1'b0, 0});
      send_frame(d, ^d, s);
      if (gap > 0) idle(gap);
    end
    idle(20);
    check("rand.count", 64'(evq.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < evq.size(); i++) begin
      e = evq[i];
      check($sformatf("rand%0d.data", i),  64'(e.data),  64'(exp_q[i].data));
      check($sformatf("rand%0d.valid", i), 64'(e.valid), 64'(exp_q[i].valid));
      check($sformatf("rand%0d.ferr", i),  64'(e.ferr),  64'(exp_q[i].ferr));
      check($sformatf("rand%0d.busy", i),  64'(e.busy),  64'd0);
    end
    evq.delete();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    expect_event("par_good", 8'h07, 1'b1, 1'b0, 1'b0);
    idle(16);
    send_frame(8'h07, 1'b0, 1'b1);
    expect_event("par_bad", 8'h07, 1'b0, 1'b0, 1'b1);
    idle(16);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  function automatic logic d_of(input logic [7:0] v, input int i);
    return v[i];
  endfunction

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the receive end of the team's 8N1 serial link. Deserialises the frame format produced by the link transmitter: start bit (0), DATA_BITS data bits LSB first, stop bit (1).
Timing comes from the shared external baud generator's baud_tick at 16x oversampling. Delivers each received byte to the host logic as a one-cycle valid pulse.

Parameters:
DATA_BITS, 8, data bits per frame (5..8).
OVERSAMPLE, 16, baud_tick pulses per bit period; must be even, >= 8.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
baud_tick  in  1  single-clk pulse at OVERSAMPLE x baud rate.
rx_line  in  1  asynchronous serial input, idle high.
data_out  out  DATA_BITS  last received word; held until the next frame completes.
rx_valid  out  1  one-clk pulse: data_out updated with a good frame.
frame_err  out  1  one-clk pulse: stop bit sampled 0.
busy  out  1  high while in any state other than IDLE.

Behaviour:
- Reset (async): state=IDLE, data_out=0, rx_valid=0, frame_err=0, busy=0, tick_cnt=0, bit_idx=0, shift register=0, synchroniser flops=1.
- rx_line passes through a 2-flop synchroniser clocked by clk (rx_s). All decisions use rx_s.
- Counters advance only on clk edges where baud_tick=1. tick_cnt is log2(OVERSAMPLE) bits wide. bit_idx is log2(DATA_BITS) bits wide, clamped to 3 bits.
- State IDLE: on a baud_tick with rx_s=0, go to START with tick_cnt=0.
- State START: count ticks. At tick OVERSAMPLE/2-1 (mid start bit), resample rx_s:
  - rx_s=0: go to DATA with tick_cnt=0, bit_idx=0.
  - rx_s=1: false start (glitch); return to IDLE with no output pulse.
- State DATA: when tick_cnt reaches OVERSAMPLE-1 (bit midpoint):
  - shift rx_s into the MSB of the shift register (right shift, so the LSB-first stream lands correctly);
  - reset tick_cnt;
  - if bit_idx=DATA_BITS-1, go to STOP; else increment bit_idx.
- State STOP: at tick OVERSAMPLE-1 (mid stop bit), copy the shift register to data_out.
  - rx_s=1: pulse rx_valid.
  - rx_s=0: pulse frame_err; rx_valid stays 0.
  - Either way, return to IDLE immediately. The second half of the stop bit is spent in IDLE, so back-to-back frames with zero idle time are received.
- Latency: rx_valid/frame_err assert on the clk edge of the stop-midpoint baud_tick and deassert on the next clk. Never both high together.
- If rx_s is stuck low after a frame error, IDLE re-detects a start on the next tick. This is required behaviour (break yields repeated frame_err).
- baud_tick low: state and counters hold. rx_valid/frame_err still clear after one clk.
- rst mid-frame: immediate abort to reset values; the partial word is discarded and no pulse is emitted.
- No tristate or X assignments on any register.

Optional Feature:
UART_RX_PARITY_EN:
- Defined:
  - a PARITY state is inserted between DATA and STOP, sampled at mid-bit like a data bit;
  - parameter ODD_PARITY (default 0) selects the polarity;
  - extra output parity_err (1 bit) pulses alongside the stop-bit decision when the received parity mismatches;
  - on a mismatch, rx_valid is suppressed; data_out still updates.
- Undefined: no PARITY state, no parity_err port, 8N1 only.

Decomposition:
- Package uart_pkg: state encoding enum (IDLE, START, DATA, PARITY, STOP; one-hot, 5 bits) and the OVERSAMPLE default constant. The link transmitter shares this package.
- Sub-module sync_2ff (parameterised width, reset value 1) for the input synchroniser; reusable elsewhere.
- All remaining logic lives in uart_rx.

Test Plan:
- Frame 0xA5 (8N1, 16 ticks/bit) -> one rx_valid pulse, data_out=0xA5, frame_err=0, busy falls on the same edge.
- 0x3C then 0xC3 back-to-back with no idle gap -> two rx_valid pulses, data_out 0x3C then 0xC3.
- Low glitch of 4 ticks on an idle line -> returns to IDLE, no rx_valid/frame_err, data_out unchanged.
- Frame 0x55 with stop bit driven 0 -> frame_err pulse, rx_valid=0, data_out=0x55. A line held low afterwards produces a repeated frame_err every 10 bit periods.
- rst asserted during data bit 4 of 0xFF -> all outputs reset immediately. A following 0x12 frame is received correctly.
- UART_RX_PARITY_EN, even parity: 0x07 with parity 1 -> rx_valid. 0x07 with parity 0 -> parity_err, no rx_valid.
